xbar_out_sched: RTL and testbench

Output-port packet scheduler for the stream crossbar. It shares one AXI-Stream master port between `NUM_REQUEST` AXI-Stream slave inputs, granting whole packets (locked until the `tlast` handshake) in round-robin order. A holder may keep the port for up to `MAX_PACKETS` consecutive packets before being forced to rotate. One instance sits in front of each crossbar output; the datapath mux is internal.

---
 rtl/xbar_pkg.sv | 23 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/xbar_out_sched.sv | 137 +++++++++++++
 tb/tb_xbar_out_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared types and width helpers for the stream crossbar schedulers.
//   sched_state_e : output scheduler FSM states (IDLE / XFER)
//   idx_width()   : bits needed to index n requesters (at least 1)
//   cnt_width()   : bits needed to count 0..max_pkts inclusive
// ---------------------------------------------------------------------------
package xbar_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } sched_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_pkts);
      return $clog2(max_pkts + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Searches req starting at index
// start and wrapping around, returning the first set bit.
//   req   [N-1:0]     : request vector
//   start [IDX_W-1:0] : index with highest priority (must be < N)
//   found             : at least one request is set
//   idx   [IDX_W-1:0] : winning index (0 when found is low)
// ---------------------------------------------------------------------------
module rr_pick
   import xbar_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      found    = 1'b0;
      idx      = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < N; i++) begin
         cand = int'(start) + i;
         if (cand >= N) cand = cand - N;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/xbar_out_sched.sv
// ---------------------------------------------------------------------------
// xbar_out_sched
// Output-port packet scheduler: shares one AXI-Stream master between
// NUM_REQUEST slave inputs, granting whole packets round-robin. A holder may
// keep the port for up to MAX_PACKETS consecutive packets, then must rotate.
// Each packet costs one IDLE (arbitration) cycle; XFER is a pure comb mux.
//   clk, rst                 : clock, asynchronous active-high reset
//   s_tvalid_i/s_tready_o    : per-input handshake
//   s_tdata_i                : input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tlast_i                : per-input last-beat flag
//   m_tvalid_o/m_tready_i    : output handshake
//   m_tdata_o, m_tlast_o     : output beat (zero outside XFER)
//   grant_o                  : one-hot current grant, zero when idle
//   busy_o                   : high while in XFER
// ---------------------------------------------------------------------------
module xbar_out_sched
   import xbar_pkg::*;
#(
   parameter int NUM_REQUEST = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_PACKETS = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQUEST-1:0]            s_tvalid_i,
   output logic [NUM_REQUEST-1:0]            s_tready_o,
   input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_tdata_i,
   input  logic [NUM_REQUEST-1:0]            s_tlast_i,
   output logic                              m_tvalid_o,
   input  logic                              m_tready_i,
   output logic [DATA_WIDTH-1:0]             m_tdata_o,
   output logic                              m_tlast_o,
   output logic [NUM_REQUEST-1:0]            grant_o,
   output logic                              busy_o
);

   localparam int IDX_W = idx_width(NUM_REQUEST);
   localparam int CNT_W = cnt_width(MAX_PACKETS);

   sched_state_e     state;
   logic [IDX_W-1:0] holder;
   logic             holder_vld;
   logic [CNT_W-1:0] pkt_cnt;

   logic [IDX_W-1:0] search_start;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             hold_ok;
   logic             sel_valid;
   logic             sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic             xfer;
   logic             last_hs;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= CNT_W'(MAX_PACKETS)) return CNT_W'(MAX_PACKETS);
      return v + CNT_W'(1);
   endfunction

   // Search begins just after the current holder so the holder itself is
   // considered last; this is what makes a lone requester at quota win again.
   assign search_start = (holder == IDX_W'(NUM_REQUEST - 1)) ? '0 : holder + IDX_W'(1);

   rr_pick #(
      .N     (NUM_REQUEST),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req   (s_tvalid_i),
      .start (search_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Constant-index mux keeps the holder select free of variable part-selects.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
         if (holder == IDX_W'(i)) begin
            sel_valid = s_tvalid_i[i];
            sel_last  = s_tlast_i[i];
            sel_data  = s_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign hold_ok = holder_vld && sel_valid && (pkt_cnt < CNT_W'(MAX_PACKETS));
   assign xfer    = (state == XFER);
   assign last_hs = xfer && sel_valid && m_tready_i && sel_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         holder     <= IDX_W'(NUM_REQUEST - 1);
         holder_vld <= 1'b0;
         pkt_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hold_ok) begin
                  state <= XFER;
               end else if (pick_found) begin
                  state      <= XFER;
                  holder     <= pick_idx;
                  holder_vld <= 1'b1;
                  pkt_cnt    <= '0;
               end
            end
            XFER: begin
               if (last_hs) begin
                  state   <= IDLE;
                  pkt_cnt <= sat_inc(pkt_cnt);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are gated by state, so an asynchronous reset forces them to
   // their idle values immediately, without waiting for a clock edge.
   always_comb begin
      grant_o    = '0;
      s_tready_o = '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
         grant_o[i]    = xfer && (holder == IDX_W'(i));
         s_tready_o[i] = xfer && (holder == IDX_W'(i)) && m_tready_i;
      end
   end

   assign m_tvalid_o = xfer && sel_valid;
   assign m_tdata_o  = xfer ? sel_data : '0;
   assign m_tlast_o  = xfer && sel_last;
   assign busy_o     = xfer;

endmodule

// File: tb/tb_xbar_out_sched.sv
// ---------------------------------------------------------------------------
// tb_xbar_out_sched
// Directed scenarios followed by a randomized run. Sources are packet queues
// that obey AXI-Stream valid/data stability. A reference model tracks owner,
// tenure count and busy flag and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_xbar_out_sched;

   localparam int N    = 4;
   localparam int DW   = 16;
   localparam int MAXP = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tready;
   logic [N*DW-1:0] s_tdata = '0;
   logic [N-1:0]    s_tlast = '0;
   logic            m_tvalid;
   logic            m_tready = 1'b1;
   logic [DW-1:0]   m_tdata;
   logic            m_tlast;
   logic [N-1:0]    grant;
   logic            busy;

   xbar_out_sched #(
      .NUM_REQUEST (N),
      .DATA_WIDTH  (DW),
      .MAX_PACKETS (MAXP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_tvalid_i (s_tvalid),
      .s_tready_o (s_tready),
      .s_tdata_i  (s_tdata),
      .s_tlast_i  (s_tlast),
      .m_tvalid_o (m_tvalid),
      .m_tready_i (m_tready),
      .m_tdata_o  (m_tdata),
      .m_tlast_o  (m_tlast),
      .grant_o    (grant),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // source state
   int q_len [N][$];
   int rem   [N];
   int beat  [N];
   int seq   [N];
   int gap_force [N];
   bit vld_now [N];
   int gap_pct = 0;
   int rdy_pct = 100;
   int rdy_plan [$];

   // reference model
   bit m_xfer;
   int m_owner;
   bit m_owner_vld;
   int m_cnt;

   // per-sample logs of DUT outputs
   logic [N-1:0]  grant_log [$];
   logic [N-1:0]  sready_log [$];
   logic [DW-1:0] data_log [$];
   logic          mv_log [$];
   logic [N-1:0]  own_log [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (!vld_now[i]) begin
            if (rem[i] == 0 && q_len[i].size() > 0) begin
               rem[i]  = q_len[i].pop_front();
               beat[i] = 0;
            end
            if (rem[i] > 0) begin
               if (beat[i] > 0 && gap_force[i] > 0)
                  gap_force[i]--;
               else if (!(beat[i] > 0 && $urandom_range(99) < gap_pct))
                  vld_now[i] = 1'b1;
            end
         end
         s_tvalid[i] = vld_now[i];
         s_tlast[i]  = vld_now[i] && (rem[i] == 1);
         s_tdata[i*DW +: DW] = DW'((i << 12) | (seq[i] & 'hfff));
      end
      if (rdy_plan.size() > 0) m_tready = (rdy_plan.pop_front() != 0);
      else                     m_tready = ($urandom_range(99) < rdy_pct);
   endtask

   task automatic model_reset();
      m_xfer      = 1'b0;
      m_owner     = N - 1;
      m_owner_vld = 1'b0;
      m_cnt       = 0;
   endtask

   // One clock: called at posedge+1 with inputs already applied.
   task automatic step();
      logic [N-1:0]  eg, er, hs;
      logic          emv, el;
      logic [DW-1:0] ed;
      bit            got;
      #4;
      eg  = m_xfer ? N'(1 << m_owner) : '0;
      er  = m_tready ? eg : '0;
      emv = m_xfer && s_tvalid[m_owner];
      el  = m_xfer && s_tlast[m_owner];
      ed  = m_xfer ? s_tdata[m_owner*DW +: DW] : '0;
      chk("grant",    32'(grant),    32'(eg));
      chk("s_tready", 32'(s_tready), 32'(er));
      chk("m_tvalid", 32'(m_tvalid), 32'(emv));
      chk("m_tlast",  32'(m_tlast),  32'(el));
      chk("m_tdata",  32'(m_tdata),  32'(ed));
      chk("busy",     32'(busy),     32'(m_xfer));
      grant_log.push_back(grant);
      sready_log.push_back(s_tready);
      data_log.push_back(m_tdata);
      mv_log.push_back(m_tvalid);
      if (m_tvalid && m_tready && m_tlast) own_log.push_back(grant);
      hs = er & s_tvalid;
      // model transition at the coming edge
      if (!m_xfer) begin
         if (m_owner_vld && s_tvalid[m_owner] && m_cnt < MAXP) begin
            m_xfer = 1'b1;
         end else begin
            got = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!got && s_tvalid[(m_owner + k) % N]) begin
                  got         = 1'b1;
                  m_owner     = (m_owner + k) % N;
                  m_owner_vld = 1'b1;
                  m_cnt       = 0;
                  m_xfer      = 1'b1;
               end
            end
         end
      end else if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) begin
         m_cnt  = (m_cnt + 1 > MAXP) ? MAXP : m_cnt + 1;
         m_xfer = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            vld_now[i] = 1'b0;
            rem[i]--;
            beat[i]++;
            seq[i]++;
         end
      end
      drive_inputs();
   endtask

   task automatic clear_logs();
      grant_log.delete();
      sready_log.delete();
      data_log.delete();
      mv_log.delete();
      own_log.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         q_len[i].delete();
         rem[i] = 0; beat[i] = 0; seq[i] = 0; gap_force[i] = 0; vld_now[i] = 1'b0;
      end
      rdy_plan.delete();
      gap_pct = 0;
      rdy_pct = 100;
      model_reset();
      drive_inputs();
      @(posedge clk);
      #1;
      chk("rst_grant",    32'(grant),    32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
      chk("rst_s_tready", 32'(s_tready), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
   endtask

   initial begin
      @(posedge clk);
      #1;

      // first grant after reset, two 2-beat packets
      do_reset();
      q_len[1].push_back(2);
      q_len[3].push_back(2);
      drive_inputs();
      for (int c = 0; c < 7; c++) step();
      begin
         logic [N-1:0] exp_g [7] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0};
         for (int c = 0; c < 7; c++) chk("first_grant_seq", 32'(grant_log[c]), 32'(exp_g[c]));
      end

      // quota: input 0 three packets, input 2 two packets
      do_reset();
      for (int p = 0; p < 3; p++) q_len[0].push_back(1);
      for (int p = 0; p < 2; p++) q_len[2].push_back(1);
      drive_inputs();
      for (int c = 0; c < 14; c++) step();
      chk("quota_pkts", 32'(own_log.size()), 32'd5);
      begin
         logic [N-1:0] exp_o [5] = '{4'h1, 4'h1, 4'h4, 4'h4, 4'h1};
         for (int p = 0; p < 5 && p < own_log.size(); p++)
            chk("quota_order", 32'(own_log[p]), 32'(exp_o[p]));
      end

      // sole requester keeps winning past its quota
      do_reset();
      for (int p = 0; p < 4; p++) q_len[1].push_back(1);
      drive_inputs();
      for (int c = 0; c < 9; c++) step();
      for (int c = 0; c < 9; c++)
         chk("sole_grant_seq", 32'(grant_log[c]), (c % 2 == 1) ? 32'h2 : 32'h0);

      // back-pressure on beat 2 of a 4-beat packet, input 3 waiting
      do_reset();
      q_len[0].push_back(4);
      q_len[3].push_back(2);
      rdy_plan = '{1, 1, 0, 0, 0, 0, 0};
      drive_inputs();
      for (int c = 0; c < 14; c++) step();
      chk("bp_beat1_data", 32'(data_log[2]), 32'h0001);
      for (int c = 2; c <= 6; c++) begin
         chk("bp_grant",  32'(grant_log[c]),  32'h1);
         chk("bp_sready", 32'(sready_log[c]), 32'h0);
         chk("bp_data",   32'(data_log[c]),   32'(data_log[2]));
      end
      chk("bp_bubble",  32'(grant_log[10]), 32'h0);
      chk("bp_next",    32'(grant_log[11]), 32'h8);

      // holder drops valid for 3 cycles mid-packet
      do_reset();
      q_len[2].push_back(3);
      gap_force[2] = 3;
      drive_inputs();
      for (int c = 0; c < 8; c++) step();
      begin
         logic [N-1:0] exp_g [8] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
         logic         exp_v [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
         for (int c = 0; c < 8; c++) begin
            chk("drop_grant",  32'(grant_log[c]), 32'(exp_g[c]));
            chk("drop_tvalid", 32'(mv_log[c]),    32'(exp_v[c]));
         end
      end

      // asynchronous reset in the middle of a packet
      do_reset();
      q_len[0].push_back(4);
      drive_inputs();
      step();
      step();
      #2;
      chk("pre_arst_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("arst_grant",    32'(grant),    32'h0);
      chk("arst_busy",     32'(busy),     32'h0);
      chk("arst_m_tvalid", 32'(m_tvalid), 32'h0);
      chk("arst_s_tready", 32'(s_tready), 32'h0);
      chk("arst_m_tdata",  32'(m_tdata),  32'h0);
      chk("arst_m_tlast",  32'(m_tlast),  32'h0);
      @(posedge clk);
      #1;

      // randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < N; i++) begin
         int np;
         np = $urandom_range(14, 6);
         for (int p = 0; p < np; p++) q_len[i].push_back($urandom_range(4, 1));
      end
      rdy_pct = 75;
      gap_pct = 15;
      drive_inputs();
      for (int c = 0; c < 1500; c++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
